bus_arbiter_rr: RTL and testbench
=================================

// Module: bus_arbiter_rr
// PURPOSE
//  N-master round-robin arbiter between per-hart BUS units and the single memory_controller port.
//  Generalises the fixed two-master arbiter to N_MASTERS, with fair rotating priority and an
//  explicit release cycle, and optionally adds atomic grant locking. Sits in multi-hart tops.
// PARAMETERS
//  N_MASTERS  2      number of requesting masters (>=2)
//  XLEN       32     data/address width (`XLEN from defines.vh)
//  OP_W       7      atomic operation field width (funct7)
//  LOCK_MAX   16     max idle cycles a lock is held before forced release (ARB_ATOMIC_LOCK_EN only)
//  ID_W       derived: max(1,$clog2(N_MASTERS)), localparam
// PORTS
//  i_clk        in   1              clock
//  i_rst        in   1              synchronous reset, active-high
//  i_bus_en     in   N              per-master request, held until that master's o_ack
//  i_wr_en      in   N              per-master write(1)/read(0)
//  i_wr_data    in   N*XLEN         per-master write data, master k at [k*XLEN +: XLEN]
//  i_addr       in   N*XLEN         per-master address
//  i_byte_en    in   N*4            per-master byte enables
//  o_ack        out  N              one-cycle completion pulse to granted master only
//  o_rd_data    out  N*XLEN         i_rd_data broadcast to every slice; qualified by o_ack
//  i_atomic     in   N              per-master atomic flag        (ARB_ATOMIC_LOCK_EN only)
//  i_operation  in   N*OP_W         per-master atomic op          (ARB_ATOMIC_LOCK_EN only)
//  i_ack        in   1              downstream completion
//  i_rd_data    in   XLEN           downstream read data
//  o_bus_en / o_wr_en / o_wr_data / o_addr / o_byte_en   out  1/1/XLEN/XLEN/4  muxed granted request
//  o_id         out  ID_W           index of granted master
//  o_atomic / o_operation  out  1/OP_W  muxed atomic fields        (ARB_ATOMIC_LOCK_EN only)
// BEHAVIOUR
//  Reset: state IDLE, rr pointer 0, grant 0; o_ack, o_bus_en, o_wr_en, o_wr_data, o_addr,
//   o_byte_en, o_id, o_atomic, o_operation all 0. Reset mid-transaction drops o_bus_en at once.
//  FSM IDLE: if |i_bus_en, grant = first requester at or after pointer (cyclic) -> register
//   grant, ->BUSY. None requesting: stay IDLE.
//  BUSY: o_bus_en=1; all downstream outputs muxed from registered grant. On i_ack:
//   o_ack[grant]=1 in the same cycle (combinational from i_ack), pointer <= grant+1 mod N
//   (wraps N-1 -> 0), ->RELEASE.
//  RELEASE: one cycle, o_bus_en=0, no arbitration (masks granted master's stale i_bus_en) -> IDLE.
//  Outside BUSY all muxed outputs are 0. Arbitration latency: request -> o_bus_en = 1 cycle.
//  i_ack outside BUSY is ignored (no o_ack). Simultaneous requests: strict rotation, no starvation;
//   a master waits at most N-1 transactions.
//  Master dropping i_bus_en in BUSY before ack is illegal; arbiter stays BUSY until i_ack.
// CONFIGURATION
//  ARB_ATOMIC_LOCK_EN defined: atomic ports present and forwarded. At ack, if i_atomic[grant]=1,
//   RELEASE -> LOCK instead of IDLE. LOCK: grant held, o_bus_en=0, lock counter increments;
//   i_bus_en[grant]=1 -> BUSY (same grant, others blocked, counter cleared);
//   i_atomic[grant]=0 or counter==LOCK_MAX -> IDLE. Pointer still advances per ack.
//  Undefined: atomic ports and LOCK state absent; o_atomic/o_operation do not exist.
// STRUCTURE
//  Shared header arbiter_defs.vh: state encodings (IDLE, BUSY, RELEASE, LOCK), ID_W clog2 helper;
//   `XLEN from defines.vh.
//  Sub-module rr_select: combinational N-way round-robin picker (req, pointer -> one-hot, index).
// TESTING
//  N=4, only master 2 requests read @0x100 -> o_bus_en next cycle, o_id=2; i_ack w/ rd 0xDEADBEEF
//   -> o_ack=4'b0100 one cycle, o_rd_data[2] = 0xDEADBEEF, RELEASE then IDLE.
//  N=4, all four request continuously -> grant order 0,1,2,3,0; each ack on correct bit only.
//  Pointer=3, masters 0 and 3 request -> 3 granted first, then 0 (wrap).
//  i_rst asserted during BUSY -> next cycle o_bus_en=0, o_ack=0, pointer 0; ack after reset ignored.
//  ARB_ATOMIC_LOCK_EN, master 1 LR with i_atomic=1, master 0 requesting -> master 1 SC granted
//   before master 0; i_atomic low in LOCK -> master 0 granted next.
//  ARB_ATOMIC_LOCK_EN, LOCK_MAX=4, locked master idle -> IDLE after 4 LOCK cycles, others granted.

Source files
------------

// File: rtl/bus_arbiter_rr_pkg.sv
// Shared definitions for the N-master round-robin bus arbiter.
package bus_arbiter_rr_pkg;

  localparam int unsigned BE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RELEASE,
    ST_LOCK
  } arb_state_e;

  // Width of a master index; at least one bit even for a single master.
  function automatic int unsigned id_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_select.sv
// Combinational round-robin picker: first requester at or after ptr, cyclically.
module rr_select
  import bus_arbiter_rr_pkg::*;
#(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned ID_W      = id_w(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] req,
  input  logic [ID_W-1:0]      ptr,
  output logic [N_MASTERS-1:0] gnt,
  output logic [ID_W-1:0]      idx,
  output logic                 valid
);

  int unsigned     k;
  logic [ID_W-1:0] k_idx;

  // Scan masters starting at ptr and take the first one requesting.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    k     = 0;
    k_idx = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      k     = (32'(ptr) + i) % N_MASTERS;
      k_idx = ID_W'(k);
      if (!valid && req[k_idx]) begin
        valid      = 1'b1;
        gnt[k_idx] = 1'b1;
        idx        = k_idx;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// N-master round-robin arbiter in front of the single memory controller port.
// Optional atomic grant locking is enabled with `define ARB_ATOMIC_LOCK_EN.
module bus_arbiter_rr
  import bus_arbiter_rr_pkg::*;
#(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned XLEN      = 32
`ifdef ARB_ATOMIC_LOCK_EN
  ,
  parameter int unsigned OP_W      = 7,
  parameter int unsigned LOCK_MAX  = 16
`endif
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [N_MASTERS-1:0]          i_bus_en,
  input  logic [N_MASTERS-1:0]          i_wr_en,
  input  logic [N_MASTERS*XLEN-1:0]     i_wr_data,
  input  logic [N_MASTERS*XLEN-1:0]     i_addr,
  input  logic [N_MASTERS*BE_W-1:0]     i_byte_en,
  output logic [N_MASTERS-1:0]          o_ack,
  output logic [N_MASTERS*XLEN-1:0]     o_rd_data,
`ifdef ARB_ATOMIC_LOCK_EN
  input  logic [N_MASTERS-1:0]          i_atomic,
  input  logic [N_MASTERS*OP_W-1:0]     i_operation,
  output logic                          o_atomic,
  output logic [OP_W-1:0]               o_operation,
`endif
  input  logic                          i_ack,
  input  logic [XLEN-1:0]               i_rd_data,
  output logic                          o_bus_en,
  output logic                          o_wr_en,
  output logic [XLEN-1:0]               o_wr_data,
  output logic [XLEN-1:0]               o_addr,
  output logic [BE_W-1:0]               o_byte_en,
  output logic [id_w(N_MASTERS)-1:0]    o_id
);

  localparam int unsigned ID_W = id_w(N_MASTERS);

  arb_state_e           state_q, state_d;
  logic [ID_W-1:0]      grant_q, grant_d;
  logic [N_MASTERS-1:0] grant_oh_q, grant_oh_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [N_MASTERS-1:0] sel_gnt;
  logic [ID_W-1:0]      sel_idx;
  logic                 sel_valid;

`ifdef ARB_ATOMIC_LOCK_EN
  localparam int unsigned LCW = $clog2(LOCK_MAX + 1);
  logic                 lock_pend_q, lock_pend_d;
  logic [LCW-1:0]       lock_cnt_q, lock_cnt_d;
`endif

  rr_select #(
    .N_MASTERS(N_MASTERS),
    .ID_W     (ID_W)
  ) u_select (
    .req  (i_bus_en),
    .ptr  (ptr_q),
    .gnt  (sel_gnt),
    .idx  (sel_idx),
    .valid(sel_valid)
  );

  // Read data is broadcast; each master qualifies it with its own o_ack bit.
  always_comb begin
    for (int unsigned m = 0; m < N_MASTERS; m++) begin
      o_rd_data[m*XLEN +: XLEN] = i_rd_data;
    end
  end

  // Downstream request mux and ack steering, live only while BUSY.
  always_comb begin
    o_ack     = '0;
    o_bus_en  = 1'b0;
    o_wr_en   = 1'b0;
    o_wr_data = '0;
    o_addr    = '0;
    o_byte_en = '0;
    o_id      = '0;
`ifdef ARB_ATOMIC_LOCK_EN
    o_atomic    = 1'b0;
    o_operation = '0;
`endif
    if (state_q == ST_BUSY) begin
      o_bus_en  = 1'b1;
      o_wr_en   = i_wr_en[grant_q];
      o_wr_data = i_wr_data[grant_q*XLEN +: XLEN];
      o_addr    = i_addr[grant_q*XLEN +: XLEN];
      o_byte_en = i_byte_en[grant_q*BE_W +: BE_W];
      o_id      = grant_q;
`ifdef ARB_ATOMIC_LOCK_EN
      o_atomic    = i_atomic[grant_q];
      o_operation = i_operation[grant_q*OP_W +: OP_W];
`endif
      if (i_ack) begin
        o_ack = grant_oh_q;
      end
    end
  end

  // Arbitration FSM next-state: IDLE -> BUSY -> RELEASE -> IDLE (or LOCK).
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_oh_d = grant_oh_q;
    ptr_d      = ptr_q;
`ifdef ARB_ATOMIC_LOCK_EN
    lock_pend_d = lock_pend_q;
    lock_cnt_d  = lock_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (sel_valid) begin
          grant_d    = sel_idx;
          grant_oh_d = sel_gnt;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (i_ack) begin
          ptr_d   = (grant_q == ID_W'(N_MASTERS - 1)) ? '0 : grant_q + ID_W'(1);
          state_d = ST_RELEASE;
`ifdef ARB_ATOMIC_LOCK_EN
          lock_pend_d = i_atomic[grant_q];
`endif
        end
      end
      ST_RELEASE: begin
`ifdef ARB_ATOMIC_LOCK_EN
        lock_pend_d = 1'b0;
        lock_cnt_d  = '0;
        state_d     = lock_pend_q ? ST_LOCK : ST_IDLE;
`else
        state_d = ST_IDLE;
`endif
      end
`ifdef ARB_ATOMIC_LOCK_EN
      ST_LOCK: begin
        // The locked master's re-request wins over both unlock conditions.
        if (i_bus_en[grant_q]) begin
          lock_cnt_d = '0;
          state_d    = ST_BUSY;
        end else if (!i_atomic[grant_q] || (lock_cnt_q + LCW'(1) == LCW'(LOCK_MAX))) begin
          lock_cnt_d = '0;
          state_d    = ST_IDLE;
        end else begin
          lock_cnt_d = lock_cnt_q + LCW'(1);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      grant_oh_q <= '0;
      ptr_q      <= '0;
`ifdef ARB_ATOMIC_LOCK_EN
      lock_pend_q <= 1'b0;
      lock_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_oh_q <= grant_oh_d;
      ptr_q      <= ptr_d;
`ifdef ARB_ATOMIC_LOCK_EN
      lock_pend_q <= lock_pend_d;
      lock_cnt_q  <= lock_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr with four masters (atomic tests need ARB_ATOMIC_LOCK_EN).
module tb_bus_arbiter_rr;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic [3:0]   i_bus_en;
  logic [3:0]   i_wr_en;
  logic [127:0] i_wr_data;
  logic [127:0] i_addr;
  logic [15:0]  i_byte_en;
  logic [3:0]   o_ack;
  logic [127:0] o_rd_data;
  logic         i_ack;
  logic [31:0]  i_rd_data;
  logic         o_bus_en;
  logic         o_wr_en;
  logic [31:0]  o_wr_data;
  logic [31:0]  o_addr;
  logic [3:0]   o_byte_en;
  logic [1:0]   o_id;
`ifdef ARB_ATOMIC_LOCK_EN
  logic [3:0]   i_atomic;
  logic [27:0]  i_operation;
  logic         o_atomic;
  logic [6:0]   o_operation;
`endif

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  bus_arbiter_rr #(
    .N_MASTERS(4),
    .XLEN     (32)
`ifdef ARB_ATOMIC_LOCK_EN
    ,
    .OP_W     (7),
    .LOCK_MAX (4)
`endif
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_bus_en   (i_bus_en),
    .i_wr_en    (i_wr_en),
    .i_wr_data  (i_wr_data),
    .i_addr     (i_addr),
    .i_byte_en  (i_byte_en),
    .o_ack      (o_ack),
    .o_rd_data  (o_rd_data),
`ifdef ARB_ATOMIC_LOCK_EN
    .i_atomic   (i_atomic),
    .i_operation(i_operation),
    .o_atomic   (o_atomic),
    .o_operation(o_operation),
`endif
    .i_ack      (i_ack),
    .i_rd_data  (i_rd_data),
    .o_bus_en   (o_bus_en),
    .o_wr_en    (o_wr_en),
    .o_wr_data  (o_wr_data),
    .o_addr     (o_addr),
    .o_byte_en  (o_byte_en),
    .o_id       (o_id)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Entered just after the edge that put the arbiter in BUSY for master id.
  // Finishes just after the next arbitration edge.
  task automatic serve(input logic [1:0] id, input logic [31:0] rd, input bit drop);
    logic [3:0] exp_ack;
    exp_ack     = '0;
    exp_ack[id] = 1'b1;
    check("busy_bus_en", 64'(o_bus_en), 64'(1));
    check("busy_id", 64'(o_id), 64'(id));
    i_ack     = 1'b1;
    i_rd_data = rd;
    #1;
    check("ack_onehot", 64'(o_ack), 64'(exp_ack));
    check("rd_data", 64'(o_rd_data[id*32 +: 32]), 64'(rd));
    step();
    i_ack = 1'b0;
    #1;
    check("release_bus_en", 64'(o_bus_en), 64'(0));
    check("release_ack", 64'(o_ack), 64'(0));
    step();
    if (drop) i_bus_en[id] = 1'b0;
    #1;
    check("idle_bus_en", 64'(o_bus_en), 64'(0));
    step();
  endtask

  initial begin
    i_rst     = 1'b1;
    i_bus_en  = '0;
    i_wr_en   = '0;
    i_wr_data = '0;
    i_addr    = '0;
    i_byte_en = '0;
    i_ack     = 1'b0;
    i_rd_data = '0;
`ifdef ARB_ATOMIC_LOCK_EN
    i_atomic    = '0;
    i_operation = '0;
`endif
    step();
    step();
    check("rst_bus_en", 64'(o_bus_en), 64'(0));
    check("rst_ack", 64'(o_ack), 64'(0));
    check("rst_id", 64'(o_id), 64'(0));
    check("rst_addr", 64'(o_addr), 64'(0));
    check("rst_wr_en", 64'(o_wr_en), 64'(0));
    check("rst_wr_data", 64'(o_wr_data), 64'(0));
    check("rst_byte_en", 64'(o_byte_en), 64'(0));
`ifdef ARB_ATOMIC_LOCK_EN
    check("rst_atomic", 64'(o_atomic), 64'(0));
    check("rst_operation", 64'(o_operation), 64'(0));
`endif
    i_rst = 1'b0;

    // Lone master 2 read at 0x100.
    i_addr[2*32 +: 32] = 32'h0000_0100;
    i_byte_en[2*4 +: 4] = 4'hF;
    i_bus_en = 4'b0100;
    #1;
    check("req_cycle_bus_en", 64'(o_bus_en), 64'(0));
    step();
    check("m2_addr", 64'(o_addr), 64'h100);
    check("m2_wr_en", 64'(o_wr_en), 64'(0));
    check("m2_byte_en", 64'(o_byte_en), 64'hF);
    serve(2'd2, 32'hDEAD_BEEF, 1'b1);
    check("no_req_bus_en", 64'(o_bus_en), 64'(0));

    // Ack with nobody granted must not produce o_ack.
    i_ack = 1'b1;
    #1;
    check("idle_ack_ignored", 64'(o_ack), 64'(0));
    step();
    i_ack = 1'b0;
    #1;
    check("idle_ack_no_busy", 64'(o_bus_en), 64'(0));

    // Pointer now at 3: masters 0 and 3 request, 3 first then wrap to 0.
    i_addr[0*32 +: 32]    = 32'h0000_0200;
    i_byte_en[0*4 +: 4]   = 4'hF;
    i_addr[3*32 +: 32]    = 32'h0000_0300;
    i_wr_en[3]            = 1'b1;
    i_wr_data[3*32 +: 32] = 32'hCAFE_F00D;
    i_byte_en[3*4 +: 4]   = 4'b0011;
    i_bus_en = 4'b1001;
    step();
    check("m3_addr", 64'(o_addr), 64'h300);
    check("m3_wr_en", 64'(o_wr_en), 64'(1));
    check("m3_wr_data", 64'(o_wr_data), 64'hCAFE_F00D);
    check("m3_byte_en", 64'(o_byte_en), 64'h3);
    serve(2'd3, 32'h1111_0003, 1'b1);
    check("m0_addr", 64'(o_addr), 64'h200);
    check("m0_wr_en", 64'(o_wr_en), 64'(0));
    check("m0_wr_data", 64'(o_wr_data), 64'(0));
    check("m0_byte_en", 64'(o_byte_en), 64'hF);
    serve(2'd0, 32'h2222_0000, 1'b1);
    i_wr_en = '0;

    // All four request continuously from pointer 0: 0,1,2,3,0.
    i_rst = 1'b1;
    step();
    i_rst    = 1'b0;
    i_bus_en = 4'b1111;
    step();
    for (int i = 0; i < 5; i++) begin
      serve(2'(i % 4), 32'hA000_0000 + 32'(i), 1'b0);
    end

    // Now BUSY on master 1 with pointer 1; reset drops the grant and pointer.
    check("pre_rst_busy", 64'(o_bus_en), 64'(1));
    i_rst = 1'b1;
    step();
    i_rst    = 1'b0;
    i_bus_en = '0;
    i_ack    = 1'b1;
    #1;
    check("rst_mid_bus_en", 64'(o_bus_en), 64'(0));
    check("rst_mid_ack", 64'(o_ack), 64'(0));
    step();
    i_ack    = 1'b0;
    i_bus_en = 4'b1001;
    #1;
    check("post_rst_idle", 64'(o_bus_en), 64'(0));
    step();
    check("ptr_reset_id", 64'(o_id), 64'(0));
    serve(2'd0, 32'h3333_0000, 1'b1);
    serve(2'd3, 32'h3333_0003, 1'b1);

`ifdef ARB_ATOMIC_LOCK_EN
    // Master 1 LR/SC pair holds the bus against master 0.
    i_rst = 1'b1;
    step();
    i_rst    = 1'b0;
    i_bus_en = '0;
    i_atomic = 4'b0010;
    i_operation[1*7 +: 7] = 7'h08;
    i_bus_en = 4'b0010;
    step();
    i_bus_en[0] = 1'b1;
    #1;
    check("lr_id", 64'(o_id), 64'(1));
    check("lr_atomic", 64'(o_atomic), 64'(1));
    check("lr_operation", 64'(o_operation), 64'h08);
    i_ack = 1'b1;
    #1;
    check("lr_ack", 64'(o_ack), 64'b0010);
    step();
    i_ack       = 1'b0;
    i_bus_en[1] = 1'b0;
    #1;
    check("lr_release", 64'(o_bus_en), 64'(0));
    step();
    check("lock_bus_en", 64'(o_bus_en), 64'(0));
    check("lock_id", 64'(o_id), 64'(0));
    i_bus_en[1] = 1'b1;
    i_operation[1*7 +: 7] = 7'h0C;
    step();
    check("sc_id", 64'(o_id), 64'(1));
    check("sc_bus_en", 64'(o_bus_en), 64'(1));
    check("sc_operation", 64'(o_operation), 64'h0C);
    i_ack = 1'b1;
    #1;
    check("sc_ack", 64'(o_ack), 64'b0010);
    step();
    i_ack       = 1'b0;
    i_bus_en[1] = 1'b0;
    step();
    i_atomic[1] = 1'b0;
    step();
    check("unlock_idle", 64'(o_bus_en), 64'(0));
    step();
    check("after_unlock_id", 64'(o_id), 64'(0));
    serve(2'd0, 32'h4444_0000, 1'b1);

    // Master 3 locks then goes quiet; the lock times out after LOCK_MAX cycles.
    i_atomic = 4'b1000;
    i_bus_en = 4'b1000;
    step();
    check("to_id", 64'(o_id), 64'(3));
    i_ack = 1'b1;
    step();
    i_ack    = 1'b0;
    i_bus_en = 4'b0100;
    step();
    check("to_lock_enter", 64'(o_bus_en), 64'(0));
    for (int c = 1; c <= 4; c++) begin
      step();
      check("to_lock_hold", 64'(o_bus_en), 64'(0));
    end
    step();
    check("to_other_bus_en", 64'(o_bus_en), 64'(1));
    check("to_other_id", 64'(o_id), 64'(2));
    i_atomic = '0;
    serve(2'd2, 32'h5555_0002, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
